// File: rtl/merc2_adc_scan_ctrl_if.sv
// ADC driver handshake for the Mercury2 scan sequencer: trigger/channel/diff select out,
// result and idle/valid flag back.
`timescale 1ns/1ps
interface merc2_adc_scan_ctrl_if;
  logic       adc_trigger;
  logic [2:0] adc_channel;
  logic       adc_diffn;
  logic [9:0] adc_dout;
  logic       adc_outval;

  modport master (
    output adc_trigger,
    output adc_channel,
    output adc_diffn,
    input  adc_dout,
    input  adc_outval
  );

  modport slave (
    input  adc_trigger,
    input  adc_channel,
    input  adc_diffn,
    output adc_dout,
    output adc_outval
  );
endinterface

// File: rtl/merc2_adc_scan_ctrl.sv
// Mercury2 ADC scan sequencer: walks a channel mask, one conversion per enabled channel.
// Optional MERC2_SCAN_AVG_EN: four conversions per channel, averaged result.
`timescale 1ns/1ps
module merc2_adc_scan_ctrl #(
  parameter int SCAN_PERIOD = 50000,
  parameter int TIMEOUT     = 255
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         continuous,
  input  logic [7:0]                   chan_mask,
  input  logic                         diffn_cfg,
  merc2_adc_scan_ctrl_if.master        adc,
  output logic [9:0]                   res_data,
  output logic [2:0]                   res_chan,
  output logic                         res_valid,
  output logic                         busy,
  output logic                         scan_done,
  output logic                         timeout_err
);

  localparam int            PW          = $clog2(SCAN_PERIOD + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SCAN_PERIOD - 1);
  localparam logic [7:0]    WAIT_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_LO, WAIT_HI, STORE, NEXT, HOLD} state_t;

  state_t        state, state_d;
  logic [7:0]    mask_q, mask_d;
  logic          cont_q, cont_d;
  logic          diffn_q, diffn_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [PW-1:0] period_cnt, period_d;
  logic [7:0]    wait_cnt, wait_d;
  logic          trig_q, trig_d;
  logic [9:0]    res_data_d;
  logic [2:0]    res_chan_d;
  logic          res_valid_d, busy_d, scan_done_d, timeout_err_d;
  logic          launch, abort, wait_expired;
  logic [3:0]    first, nxt;
`ifdef MERC2_SCAN_AVG_EN
  logic [11:0]   acc_q, acc_d, acc_sum;
  logic [1:0]    samp_q, samp_d;
`endif

  // Index of the lowest set bit at or above 'from'; bit 3 set means none found.
  function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'b1000;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= from)) r = 4'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state;
    mask_d        = mask_q;
    cont_d        = cont_q;
    diffn_d       = diffn_q;
    ptr_d         = ptr_q;
    period_d      = (period_cnt == PERIOD_LAST) ? period_cnt : period_cnt + PW'(1);
    wait_d        = wait_cnt + 8'd1;
    trig_d        = 1'b0;
    res_data_d    = res_data;
    res_chan_d    = res_chan;
    res_valid_d   = 1'b0;
    busy_d        = busy;
    scan_done_d   = 1'b0;
    timeout_err_d = timeout_err;
    launch        = 1'b0;
    abort         = 1'b0;
    wait_expired  = (wait_cnt == WAIT_LAST);
    first         = find_from(chan_mask, 4'd0);
    nxt           = find_from(mask_q, {1'b0, ptr_q} + 4'd1);
`ifdef MERC2_SCAN_AVG_EN
    acc_d         = acc_q;
    samp_d        = samp_q;
    acc_sum       = acc_q + {2'b00, adc.adc_dout};
`endif

    case (state)
      IDLE: begin
        if (start) begin
          timeout_err_d = 1'b0;
          if (first[3]) scan_done_d = 1'b1;
          else          launch      = 1'b1;
        end
      end
      TRIG: begin
        if (adc.adc_outval) begin
          trig_d  = 1'b1;
          state_d = WAIT_LO;
        end else if (wait_expired) begin
          abort = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!adc.adc_outval)  state_d = WAIT_HI;
        else if (wait_expired) abort  = 1'b1;
      end
      WAIT_HI: begin
        if (adc.adc_outval) begin
`ifdef MERC2_SCAN_AVG_EN
          if (samp_q == 2'd3) begin
            res_data_d  = acc_sum[11:2];
            res_chan_d  = ptr_q;
            res_valid_d = 1'b1;
            state_d     = STORE;
          end else begin
            acc_d   = acc_sum;
            samp_d  = samp_q + 2'd1;
            state_d = TRIG;
          end
`else
          res_data_d  = adc.adc_dout;
          res_chan_d  = ptr_q;
          res_valid_d = 1'b1;
          state_d     = STORE;
`endif
        end else if (wait_expired) begin
          abort = 1'b1;
        end
      end
      STORE: state_d = NEXT;
      NEXT: begin
        if (!nxt[3]) begin
          ptr_d   = nxt[2:0];
          state_d = TRIG;
`ifdef MERC2_SCAN_AVG_EN
          acc_d   = '0;
          samp_d  = '0;
`endif
        end else begin
          scan_done_d = 1'b1;
          if (cont_q) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      HOLD: begin
        if (!continuous) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (period_cnt == PERIOD_LAST) begin
          // An empty mask at a periodic restart still marks the period as scanned.
          if (first[3]) begin
            scan_done_d = 1'b1;
            period_d    = '0;
          end else begin
            launch = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      mask_d   = chan_mask;
      cont_d   = continuous;
      diffn_d  = diffn_cfg;
      ptr_d    = first[2:0];
      period_d = '0;
      busy_d   = 1'b1;
      state_d  = TRIG;
`ifdef MERC2_SCAN_AVG_EN
      acc_d    = '0;
      samp_d   = '0;
`endif
    end

    if (abort) begin
      timeout_err_d = 1'b1;
      scan_done_d   = 1'b1;
      if (cont_q) begin
        state_d = HOLD;
      end else begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end

    if (state_d != state) wait_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mask_q      <= '0;
      cont_q      <= 1'b0;
      diffn_q     <= 1'b0;
      ptr_q       <= '0;
      period_cnt  <= '0;
      wait_cnt    <= '0;
      trig_q      <= 1'b0;
      res_data    <= '0;
      res_chan    <= '0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      mask_q      <= mask_d;
      cont_q      <= cont_d;
      diffn_q     <= diffn_d;
      ptr_q       <= ptr_d;
      period_cnt  <= period_d;
      wait_cnt    <= wait_d;
      trig_q      <= trig_d;
      res_data    <= res_data_d;
      res_chan    <= res_chan_d;
      res_valid   <= res_valid_d;
      busy        <= busy_d;
      scan_done   <= scan_done_d;
      timeout_err <= timeout_err_d;
    end
  end

`ifdef MERC2_SCAN_AVG_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      samp_q <= '0;
    end else begin
      acc_q  <= acc_d;
      samp_q <= samp_d;
    end
  end
`endif

  assign adc.adc_trigger = trig_q;
  assign adc.adc_channel = ptr_q;
  assign adc.adc_diffn   = diffn_q;

endmodule

// File: tb/tb_merc2_adc_scan_ctrl.sv
// Bench for merc2_adc_scan_ctrl: behavioural ADC driver model plus an expected-result queue
// built from the mask and the ADC's incrementing output.
`timescale 1ns/1ps
module tb_merc2_adc_scan_ctrl;
  localparam int SCAN_PERIOD = 500;
  localparam int TIMEOUT     = 255;
  localparam int CONV_TIME   = 82;
`ifdef MERC2_SCAN_AVG_EN
  localparam int SAMPLES = 4;
`else
  localparam int SAMPLES = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [7:0] chan_mask = 8'h00;
  logic       diffn_cfg = 1'b0;
  logic [9:0] res_data;
  logic [2:0] res_chan;
  logic       res_valid, busy, scan_done, timeout_err;

  merc2_adc_scan_ctrl_if adc_bus();

  merc2_adc_scan_ctrl #(.SCAN_PERIOD(SCAN_PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .continuous(continuous),
    .chan_mask(chan_mask), .diffn_cfg(diffn_cfg), .adc(adc_bus),
    .res_data(res_data), .res_chan(res_chan), .res_valid(res_valid),
    .busy(busy), .scan_done(scan_done), .timeout_err(timeout_err)
  );

  always #10 clock = ~clock;

  // ADC driver model: accepts a trigger only when idle, output value counts accepted triggers.
  logic [9:0] model_dout   = 10'd1;
  logic       model_outval = 1'b1;
  int         model_cnt    = 0;
  bit         adc_stuck    = 1'b0;
  assign adc_bus.adc_dout   = model_dout;
  assign adc_bus.adc_outval = model_outval;

  always @(posedge clock) begin
    if (adc_bus.adc_trigger && model_outval && !adc_stuck) begin
      model_dout   <= model_dout + 10'd1;
      model_outval <= 1'b0;
      model_cnt    <= CONV_TIME;
    end else if (!model_outval) begin
      if (model_cnt <= 1) model_outval <= 1'b1;
      else                model_cnt    <= model_cnt - 1;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [12:0] got_q[$];
  logic [12:0] exp_q[$];
  int res_cyc_q[$];
  int trig_count, done_count, first_trig_cyc, last_done_cyc, start_cyc;
  logic diffn_at_trig;
  int next_val = 1;
  int checks = 0;
  int errors = 0;

  always @(negedge clock) begin
    if (res_valid) begin
      got_q.push_back({res_chan, res_data});
      res_cyc_q.push_back(cyc);
    end
    if (adc_bus.adc_trigger) begin
      trig_count++;
      if (first_trig_cyc < 0) begin
        first_trig_cyc = cyc;
        diffn_at_trig  = adc_bus.adc_diffn;
      end
    end
    if (scan_done) begin
      done_count++;
      last_done_cyc = cyc;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    res_cyc_q.delete();
    trig_count     = 0;
    done_count     = 0;
    first_trig_cyc = -1;
    last_done_cyc  = -1;
  endtask

  // Expected results: ascending enabled channels, each the mean of the next SAMPLES ADC values.
  task automatic build_expected(input logic [7:0] mask);
    exp_q.delete();
    for (int ch = 0; ch < 8; ch++) begin
      if (mask[ch]) begin
        int sum = 0;
        for (int s = 0; s < SAMPLES; s++) begin
          next_val++;
          sum += next_val;
        end
        exp_q.push_back({3'(ch), 10'(sum / SAMPLES)});
      end
    end
  endtask

  task automatic pulse_start(input logic [7:0] mask, input logic cont, input logic diffn);
    @(posedge clock);
    #1;
    chan_mask  = mask;
    continuous = cont;
    diffn_cfg  = diffn;
    start      = 1'b1;
    start_cyc  = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit timed_out);
    int n = 0;
    while (done_count == 0 && n < bound) begin
      @(posedge clock);
      n++;
    end
    #1;
    timed_out = (done_count == 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({res_data, res_chan, res_valid, busy, scan_done, timeout_err,
         adc_bus.adc_trigger, adc_bus.adc_channel, adc_bus.adc_diffn} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h want 0", {res_data, res_chan, res_valid, busy,
               scan_done, timeout_err, adc_bus.adc_trigger, adc_bus.adc_channel, adc_bus.adc_diffn});
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_scan(input logic [7:0] mask, input logic diffn, input bit inject,
                           input bit check_latency);
    int sc;
    bit to;
    clear_mon();
    build_expected(mask);
    pulse_start(mask, 1'b0, diffn);
    sc = start_cyc;
    if (inject) begin
      repeat (5) @(posedge clock);
      #1;
      chan_mask = ~mask;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    wait_done(8 * SAMPLES * (CONV_TIME + 20) + 300, to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL scan_done_wait mask %h got no scan_done want one", mask);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL result_count mask %h got %0d want %0d", mask, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL result[%0d] mask %h got ch%0d/%0d want ch%0d/%0d", i, mask,
                   got_q[i][12:10], got_q[i][9:0], exp_q[i][12:10], exp_q[i][9:0]);
        end
      end
    end
    checks++;
    if (trig_count != exp_q.size() * SAMPLES) begin
      errors++;
      $display("[TB] FAIL trigger_count mask %h got %0d want %0d", mask, trig_count,
               exp_q.size() * SAMPLES);
    end
    if (check_latency) begin
      checks++;
      if (first_trig_cyc - sc != 2) begin
        errors++;
        $display("[TB] FAIL first_trigger_latency got %0d want 2", first_trig_cyc - sc);
      end
    end
    checks++;
    if (diffn_at_trig !== diffn) begin
      errors++;
      $display("[TB] FAIL adc_diffn got %b want %b", diffn_at_trig, diffn);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy, timeout_err} !== 2'b00 || done_count != 1) begin
      errors++;
      $display("[TB] FAIL scan_end busy/timeout_err got %b%b done %0d want 00 done 1",
               busy, timeout_err, done_count);
    end
  endtask

  task automatic test_empty_mask();
    clear_mon();
    pulse_start(8'h00, 1'b0, 1'b0);
    checks++;
    if ({scan_done, busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL empty_mask_strobe got done %b busy %b want 1 0", scan_done, busy);
    end
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (trig_count != 0 || done_count != 1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_mask_after got trig %0d done %0d busy %b want 0 1 0",
               trig_count, done_count, busy);
    end
  endtask

  task automatic test_timeout();
    bit to;
    adc_stuck = 1'b1;
    clear_mon();
    pulse_start(8'(($urandom_range(1, 255))), 1'b0, 1'b0);
    wait_done(TIMEOUT + 100, to);
    checks++;
    if (to) begin
      errors++;
      $display("[TB] FAIL timeout_abort got no scan_done want one");
    end
    checks++;
    if (timeout_err !== 1'b1 || got_q.size() != 0 || trig_count != 1) begin
      errors++;
      $display("[TB] FAIL timeout_state got err %b results %0d trig %0d want 1 0 1",
               timeout_err, got_q.size(), trig_count);
    end
    checks++;
    if (last_done_cyc - first_trig_cyc != TIMEOUT) begin
      errors++;
      $display("[TB] FAIL timeout_length got %0d want %0d", last_done_cyc - first_trig_cyc, TIMEOUT);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_sticky got busy %b err %b want 0 1", busy, timeout_err);
    end
    adc_stuck = 1'b0;
  endtask

  task automatic test_continuous();
    int n = 0;
    clear_mon();
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      int sum = 0;
      for (int s = 0; s < SAMPLES; s++) begin
        next_val++;
        sum += next_val;
      end
      exp_q.push_back({3'd7, 10'(sum / SAMPLES)});
    end
    pulse_start(8'h80, 1'b1, 1'b0);
    while (got_q.size() < 3 && n < 3 * SCAN_PERIOD + 500) begin
      @(posedge clock);
      n++;
    end
    #1;
    continuous = 1'b0;
    repeat (SCAN_PERIOD + 100) @(posedge clock);
    #1;
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("[TB] FAIL continuous_count got %0d want 3", got_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL continuous_result[%0d] got ch%0d/%0d want ch%0d/%0d", i,
                   got_q[i][12:10], got_q[i][9:0], exp_q[i][12:10], exp_q[i][9:0]);
        end
      end
      if (i > 0 && i < got_q.size()) begin
        checks++;
        if (res_cyc_q[i] - res_cyc_q[i-1] != SCAN_PERIOD) begin
          errors++;
          $display("[TB] FAIL continuous_period[%0d] got %0d want %0d", i,
                   res_cyc_q[i] - res_cyc_q[i-1], SCAN_PERIOD);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || done_count != 3 || trig_count != 3 * SAMPLES) begin
      errors++;
      $display("[TB] FAIL continuous_stop got busy %b done %0d trig %0d want 0 3 %0d",
               busy, done_count, trig_count, 3 * SAMPLES);
    end
  endtask

  task automatic test_reset_mid_conversion();
    int n = 0;
    clear_mon();
    pulse_start(8'h08, 1'b0, 1'b1);
    while (first_trig_cyc < 0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    checks++;
    if (first_trig_cyc < 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_trigger got no trigger want one");
    end else begin
      next_val++;
    end
    repeat (40) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({res_data, res_chan, res_valid, busy, scan_done, timeout_err,
         adc_bus.adc_trigger, adc_bus.adc_channel, adc_bus.adc_diffn} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs got %h want 0", {res_data, res_chan, res_valid, busy,
               scan_done, timeout_err, adc_bus.adc_trigger, adc_bus.adc_channel, adc_bus.adc_diffn});
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    test_scan(8'h01, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random_scans();
    for (int k = 0; k < 6; k++) begin
      logic [7:0] m;
      m = 8'($urandom_range(1, 255));
      test_scan(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_scan(8'h05, 1'b0, 1'b0, 1'b1);
    test_empty_mask();
    test_timeout();
    test_scan(8'h81, 1'b1, 1'b1, 1'b1);
    test_continuous();
    test_reset_mid_conversion();
    test_random_scans();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got no completion want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
